seq_detect_param: RTL and testbench



---
 rtl/seq_detect_param_if.sv | 27 ++
 rtl/seq_detect_param.sv | 67 ++++++
 tb/tb_seq_detect_param.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seq_detect_param_if.sv
// Serial-stream bundle for seq_detect_param: sample qualifier, data bit,
// counter clear, and the detector's match pulse and match count.
interface seq_detect_param_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             x;
    logic             cnt_clr;
    logic             y;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en,
        output x,
        output cnt_clr,
        input  y,
        input  match_cnt
    );

    modport slave (
        input  en,
        input  x,
        input  cnt_clr,
        output y,
        output match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with overlap/non-overlap matching,
// Mealy/Moore pulse timing, an input-valid qualifier and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned        LEN     = 4,
    parameter logic [LEN-1:0]     PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter bit                 MEALY   = 1'b0,
    parameter int unsigned        CNT_W   = 8
) (
    input logic               clk,
    input logic               reset,
    seq_detect_param_if.slave bus
);
    localparam int unsigned    FW       = $clog2(LEN);
    localparam logic [FW-1:0]  FILL_MAX = FW'(LEN - 1);

    logic [LEN-2:0]   hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN-1:0]   window;
    logic             hit;

    // Fill gating keeps reset contents of hist from matching all-zero patterns.
    assign window = {hist_q, bus.x};
    assign hit    = bus.en && (fill_q == FILL_MAX) && (window == PATTERN);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (bus.en) begin
            hist_d = window[LEN-2:0];
            if (hit && !OVERLAP) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_comb begin
        y_d   = hit;
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.y         = MEALY ? hit : y_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: five parameterisations share one stimulus stream.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic reset, en, x, cnt_clr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_detect_param_if #(.CNT_W(8)) if_a ();
    seq_detect_param_if #(.CNT_W(8)) if_b ();
    seq_detect_param_if #(.CNT_W(8)) if_c ();
    seq_detect_param_if #(.CNT_W(8)) if_d ();
    seq_detect_param_if #(.CNT_W(2)) if_e ();

    assign if_a.en = en;  assign if_a.x = x;  assign if_a.cnt_clr = cnt_clr;
    assign if_b.en = en;  assign if_b.x = x;  assign if_b.cnt_clr = cnt_clr;
    assign if_c.en = en;  assign if_c.x = x;  assign if_c.cnt_clr = cnt_clr;
    assign if_d.en = en;  assign if_d.x = x;  assign if_d.cnt_clr = cnt_clr;
    assign if_e.en = en;  assign if_e.x = x;  assign if_e.cnt_clr = cnt_clr;

    // a: overlap Moore; b: non-overlap Moore; c: all-zero pattern; d: Mealy; e: 2-bit counter
    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b0), .CNT_W(8))
        u_a (.clk(clk), .reset(reset), .bus(if_a));
    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MEALY(1'b0), .CNT_W(8))
        u_b (.clk(clk), .reset(reset), .bus(if_b));
    seq_detect_param #(.LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .MEALY(1'b0), .CNT_W(8))
        u_c (.clk(clk), .reset(reset), .bus(if_c));
    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b1), .CNT_W(8))
        u_d (.clk(clk), .reset(reset), .bus(if_d));
    seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b0), .CNT_W(2))
        u_e (.clk(clk), .reset(reset), .bus(if_e));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; x = 1'b0; cnt_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    bit   p1_x  [7] = '{1, 0, 1, 1, 0, 1, 1};
    bit   p1_ha [7] = '{0, 0, 0, 1, 0, 0, 1};
    bit   p1_hb [7] = '{0, 0, 0, 1, 0, 0, 0};
    bit   p3_en [7] = '{1, 1, 0, 0, 0, 1, 1};
    logic p3_x  [7] = '{1'b1, 1'b0, 1'b1, 1'bx, 1'b0, 1'b1, 1'b1};
    bit   p3_h  [7] = '{0, 0, 0, 0, 0, 0, 1};
    bit   p5_x  [5] = '{1, 1, 0, 1, 1};
    bit   p5_h  [5] = '{0, 0, 0, 0, 1};
    bit   pre_x [3] = '{1, 0, 1};

    initial begin
        int  ca, cb, cc, ce;
        bit  h;

        // Reset state of every instance
        do_reset();
        chk("rst a.y", if_a.y, 0);        chk("rst a.cnt", if_a.match_cnt, 0);
        chk("rst b.y", if_b.y, 0);        chk("rst c.y", if_c.y, 0);
        chk("rst d.y", if_d.y, 0);        chk("rst e.cnt", if_e.match_cnt, 0);

        // Overlapping vs non-overlapping on 1,0,1,1,0,1,1
        ca = 0; cb = 0;
        for (int i = 0; i < 7; i++) begin
            en = 1'b1; x = p1_x[i];
            #1;
            chk($sformatf("p1 d.y mealy edge%0d", i + 1), if_d.y, p1_ha[i]);
            tick();
            if (p1_ha[i]) ca++;
            if (p1_hb[i]) cb++;
            chk($sformatf("p1 a.y edge%0d", i + 1), if_a.y, p1_ha[i]);
            chk($sformatf("p1 a.cnt edge%0d", i + 1), if_a.match_cnt, ca);
            chk($sformatf("p1 b.y edge%0d", i + 1), if_b.y, p1_hb[i]);
            chk($sformatf("p1 b.cnt edge%0d", i + 1), if_b.match_cnt, cb);
            chk($sformatf("p1 c.y edge%0d", i + 1), if_c.y, 0);
        end
        en = 1'b0;
        tick();
        chk("p1 a.y drop", if_a.y, 0);
        chk("p1 a.cnt final", if_a.match_cnt, 2);
        chk("p1 b.cnt final", if_b.match_cnt, 1);
        chk("p1 d.cnt final", if_d.match_cnt, 2);

        // All-zero pattern: fill gating, then back-to-back pulses
        do_reset();
        cc = 0;
        for (int i = 0; i < 6; i++) begin
            en = 1'b1; x = 1'b0;
            tick();
            h = (i >= 3);
            if (h) cc++;
            chk($sformatf("p2 c.y edge%0d", i + 1), if_c.y, h);
            chk($sformatf("p2 c.cnt edge%0d", i + 1), if_c.match_cnt, cc);
        end
        en = 1'b0;
        tick();
        chk("p2 c.y drop", if_c.y, 0);

        // Qualifier gap with toggling (and unknown) x
        do_reset();
        for (int i = 0; i < 7; i++) begin
            en = p3_en[i]; x = p3_x[i];
            #1;
            chk($sformatf("p3 d.y mealy step%0d", i + 1), if_d.y, p3_h[i]);
            tick();
            chk($sformatf("p3 a.y step%0d", i + 1), if_a.y, p3_h[i]);
        end
        en = 1'b0;
        #1;
        chk("p3 d.y idle", if_d.y, 0);
        chk("p3 d.cnt", if_d.match_cnt, 1);
        tick();
        chk("p3 a.y drop", if_a.y, 0);
        chk("p3 a.cnt", if_a.match_cnt, 1);

        // Counter saturation at 3, then clear beats a simultaneous 6th hit
        do_reset();
        ce = 0;
        for (int i = 0; i < 19; i++) begin
            en = 1'b1;
            x = (i == 0) ? 1'b1 : ((i % 3) != 1);
            cnt_clr = (i == 18);
            tick();
            h = (i >= 3) && ((i % 3) == 0);
            if (i == 18) ce = 0;
            else if (h && ce < 3) ce++;
            chk($sformatf("p4 e.y edge%0d", i + 1), if_e.y, h);
            chk($sformatf("p4 e.cnt edge%0d", i + 1), if_e.match_cnt, ce);
        end
        en = 1'b0; cnt_clr = 1'b0;
        tick();
        chk("p4 e.y drop", if_e.y, 0);
        chk("p4 e.cnt after clr", if_e.match_cnt, 0);

        // Mid-sequence reset; reset also overrides a would-be hit on the same edge
        do_reset();
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; x = pre_x[i];
            tick();
        end
        reset = 1'b1; en = 1'b1; x = 1'b1;
        tick();
        reset = 1'b0; en = 1'b0;
        #1;
        chk("p5 a.y post-rst", if_a.y, 0);
        chk("p5 a.cnt post-rst", if_a.match_cnt, 0);
        chk("p5 b.y post-rst", if_b.y, 0);
        chk("p5 d.y post-rst", if_d.y, 0);
        chk("p5 e.cnt post-rst", if_e.match_cnt, 0);
        ca = 0;
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; x = p5_x[i];
            #1;
            chk($sformatf("p5 d.y mealy step%0d", i + 1), if_d.y, p5_h[i]);
            tick();
            if (p5_h[i]) ca++;
            chk($sformatf("p5 a.y step%0d", i + 1), if_a.y, p5_h[i]);
            chk($sformatf("p5 a.cnt step%0d", i + 1), if_a.match_cnt, ca);
        end
        en = 1'b0;
        tick();
        chk("p5 a.y drop", if_a.y, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
